// File: rtl/ser_pkg.sv
// Shared serial-link definitions: state encoding and frame levels.
// Used by both the transmitter and the matching deserializer.
package ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/ser_tx4_bit_timer.sv
// Bit-period down-counter: tick marks the last clock of a period,
// pre_tick says the next clock will be the last one.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic restart,
    output logic tick,
    output logic pre_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (restart || tick) begin
            cnt_d = RELOAD;
        end
        pre_tick = (cnt_d == '0);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ser_tx4.sv
// Parallel-to-serial transmitter: start bit, DATA_W bits LSB-first,
// stop bit, each held CLKS_PER_BIT clocks, LOAD/READY handshake.
module ser_tx4 #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] D_IN,
    input  logic              LOAD,
    output logic              READY,
    output logic              TX,
    output logic              DONE
);

    import ser_pkg::*;

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] shifted;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              tx_q, tx_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              accept;
    logic              tick;
    logic              pre_tick;

    assign accept = LOAD && ready_q;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .restart (accept),
        .tick    (tick),
        .pre_tick(pre_tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        shifted   = shift_q >> 1;
        unique case (state_q)
            IDLE: begin
                tx_d    = IDLE_LEVEL;
                ready_d = 1'b1;
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shifted;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = STOP;
                        bit_cnt_d = '0;
                        tx_d      = STOP_BIT;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = shifted[0];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    tx_d    = IDLE_LEVEL;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end
            end
        endcase
        // Open the handshake one clock early so a held LOAD chains frames.
        if (state_d == STOP && pre_tick) begin
            ready_d = 1'b1;
        end
        if (accept) begin
            state_d   = START;
            shift_d   = D_IN;
            bit_cnt_d = '0;
            tx_d      = START_BIT;
            ready_d   = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= IDLE_LEVEL;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    assign TX    = tx_q;
    assign READY = ready_q;
    assign DONE  = done_q;

endmodule

// File: tb/tb_ser_tx4.sv
// Directed bench for ser_tx4: default 4-bit/4-clock instance and an
// 8-bit/1-clock instance, hand-computed line levels per frame.
module tb_ser_tx4;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [3:0] d_in = '0;
    logic       load = 1'b0;
    logic       ready, tx, done;
    logic [7:0] d_in8 = '0;
    logic       load8 = 1'b0;
    logic       ready8, tx8, done8;
    logic [9:0] lvl8;

    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    ser_tx4 dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .D_IN (d_in),
        .LOAD (load),
        .READY(ready),
        .TX   (tx),
        .DONE (done)
    );

    ser_tx4 #(
        .DATA_W      (8),
        .CLKS_PER_BIT(1)
    ) dut8 (
        .CLK  (CLK),
        .RST_N(RST_N),
        .D_IN (d_in8),
        .LOAD (load8),
        .READY(ready8),
        .TX   (tx8),
        .DONE (done8)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Entered at the negedge of cycle 0 (just after the accepting edge);
    // returns at the negedge of cycle 24. lvl[i] is the level of bit i.
    task automatic expect_frame(input string name, input logic [5:0] lvl,
                                input int poke_c, input logic [3:0] poke_d);
        for (int c = 0; c < 24; c++) begin
            chk($sformatf("%s tx c%0d", name, c), 32'(tx), 32'(lvl[c/4]));
            if (c > 0)
                chk($sformatf("%s done c%0d", name, c), 32'(done), 32'd0);
            if (c == poke_c) begin
                load = 1'b1;
                d_in = poke_d;
            end else if (c == poke_c + 1) begin
                load = 1'b0;
            end
            @(negedge CLK);
        end
    endtask

    initial begin
        // reset held with clock running
        repeat (3) begin
            @(negedge CLK);
            chk("rst tx", 32'(tx), 32'd1);
            chk("rst ready", 32'(ready), 32'd1);
            chk("rst done", 32'(done), 32'd0);
        end
        chk("rst tx8", 32'(tx8), 32'd1);

        // single frame 1011
        RST_N = 1'b1;
        d_in = 4'b1011;
        load = 1'b1;
        @(negedge CLK);
        load = 1'b0;
        d_in = 4'b0100;
        expect_frame("single", 6'b110110, -10, 4'b0000);
        chk("single done", 32'(done), 32'd1);
        chk("single ready", 32'(ready), 32'd1);
        chk("single idle tx", 32'(tx), 32'd1);
        @(negedge CLK);
        chk("single done clr", 32'(done), 32'd0);

        // back-to-back 0001 then 1000 with LOAD held
        load = 1'b1;
        d_in = 4'b0001;
        @(negedge CLK);
        d_in = 4'b1000;
        expect_frame("b2b0", 6'b100010, -10, 4'b0000);
        chk("b2b0 done", 32'(done), 32'd1);
        chk("b2b1 start", 32'(tx), 32'd0);
        load = 1'b0;
        expect_frame("b2b1", 6'b110000, -10, 4'b0000);
        chk("b2b1 done", 32'(done), 32'd1);
        chk("b2b1 ready", 32'(ready), 32'd1);
        @(negedge CLK);
        chk("b2b1 done clr", 32'(done), 32'd0);

        // LOAD of 1111 at clock 5 of a 0000 frame is ignored
        load = 1'b1;
        d_in = 4'b0000;
        @(negedge CLK);
        load = 1'b0;
        expect_frame("busy", 6'b100000, 5, 4'b1111);
        chk("busy done", 32'(done), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk($sformatf("busy nodone %0d", i), 32'(done), 32'd0);
            chk($sformatf("busy idle %0d", i), 32'(tx), 32'd1);
        end

        // reset at clock 10 of a frame
        load = 1'b1;
        d_in = 4'b0000;
        @(negedge CLK);
        load = 1'b0;
        repeat (10) @(negedge CLK);
        chk("mid tx pre", 32'(tx), 32'd0);
        RST_N = 1'b0;
        #1;
        chk("mid tx async", 32'(tx), 32'd1);
        chk("mid ready async", 32'(ready), 32'd1);
        chk("mid done async", 32'(done), 32'd0);
        @(negedge CLK);
        chk("mid done held", 32'(done), 32'd0);
        RST_N = 1'b1;
        load = 1'b1;
        d_in = 4'b0110;
        @(negedge CLK);
        load = 1'b0;
        expect_frame("after rst", 6'b101100, -10, 4'b0000);
        chk("after rst done", 32'(done), 32'd1);

        // 8-bit, one clock per bit, A5
        lvl8 = 10'b1101001010;
        load8 = 1'b1;
        d_in8 = 8'hA5;
        @(negedge CLK);
        load8 = 1'b0;
        d_in8 = 8'h00;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("w8 tx c%0d", c), 32'(tx8), 32'(lvl8[c]));
            chk($sformatf("w8 done c%0d", c), 32'(done8), 32'd0);
            @(negedge CLK);
        end
        chk("w8 done", 32'(done8), 32'd1);
        chk("w8 ready", 32'(ready8), 32'd1);
        @(negedge CLK);
        chk("w8 done clr", 32'(done8), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
